// File: rtl/dcache_access.sv
// dcache_access: memory-stage load/store sequencer driving a request/grant/response data port.
// Optional: define DCACHE_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module dcache_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [2:0]  rwidth,
    input  logic        rsign,
    input  logic        wen,
    input  logic [2:0]  wwidth,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        ld_valid,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic        is_load, sign_q;
    logic [2:0]  width_q;
    logic [1:0]  lo_q;
    logic [2:0]  w;
    logic        start, mis;
    logic [1:0]  lo;
    logic [3:0]  be;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] wd, ext;

    // decode the presented access into its lane, byte enables and replicated store data; extend load data
    always_comb begin
        w = ren ? rwidth : wwidth;
        start = (ren | wen) & (w == 3'd1 | w == 3'd2 | w == 3'd4);
        lo = w == 3'd4 ? 2'b00 : w == 3'd2 ? {addr[1], 1'b0} : addr[1:0];
        be = w == 3'd4 ? 4'b1111 : w == 3'd2 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lo;
        wd = w == 3'd1 ? {4{wdata[7:0]}} : w == 3'd2 ? {2{wdata[15:0]}} : wdata;
`ifdef DCACHE_MISALIGN_TRAP_EN
        mis = start & (w == 3'd2 ? addr[0] : w == 3'd4 ? |addr[1:0] : 1'b0);
`else
        mis = 1'b0;
`endif
        stall = ((state == IDLE) & start) | (state == REQ) | (state == WAIT);
        b = mem_rdata[{lo_q, 3'b000} +: 8];
        h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext = width_q == 3'd1 ? {{24{sign_q & b[7]}}, b} :
              width_q == 3'd2 ? {{16{sign_q & h[15]}}, h} : mem_rdata;
    end

    // access sequencer: latch on accept, hold the request until granted, capture the load response
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_load   <= 1'b0;
            sign_q    <= 1'b0;
            width_q   <= 3'd0;
            lo_q      <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            ld_valid  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (mis) begin
                        state    <= DONE;
                        misalign <= 1'b1;
                    end else begin
                        state     <= REQ;
                        is_load   <= ren;
                        sign_q    <= rsign;
                        width_q   <= w;
                        lo_q      <= lo;
                        mem_req   <= 1'b1;
                        mem_we    <= ~ren;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be;
                        mem_wdata <= wd;
                    end
                end
                REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= is_load ? WAIT : DONE;
                end
                WAIT: if (mem_rvalid) begin
                    rdata    <= ext;
                    ld_valid <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dcache_access.md
# dcache_access

Memory-stage access sequencer placed directly downstream of `dcache_decoder`. It consumes the decoded `ren/rwidth/rsign/wen/wwidth` controls together with the execute-stage address and store data. It drives a single request/grant/response data-memory port and stalls the pipeline while an access is outstanding. For loads it returns the lane-extracted, sign- or zero-extended result; for stores it generates byte enables and lane-replicated write data.

## Interface
No parameters; data and address paths are fixed at 32 bits.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ren`, `rsign`, `wen` in 1: decoded controls.
- `rwidth`, `wwidth` in 3: access width in bytes (1, 2 or 4).
- `addr` in 32: byte address.
- `wdata` in 32: store data, low-aligned.
- `stall` out 1: pipeline must hold all inputs stable while high.
- `rdata` out 32: extended load result.
- `ld_valid` out 1: one-cycle pulse, `rdata` valid.
- `misalign` out 1: one-cycle fault pulse.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (word-aligned), `mem_be` out 4, `mem_wdata` out 32.
- `mem_gnt` in 1, `mem_rvalid` in 1, `mem_rdata` in 32.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Access start in IDLE: `ren` with `rwidth` ∈ {1,2,4}, or `wen` with `wwidth` ∈ {1,2,4}.
  - `ren` has priority if both are set.
  - Any other width means no access.
- On start: latch type, width, sign, `addr` and `wdata`, then go to REQ.
- REQ: `mem_req`=1 with stable address, enables and data. Stays in REQ until `mem_gnt`. On grant, a store goes to DONE and a load goes to WAIT.
- WAIT: stays until `mem_rvalid`. Latches the extended `mem_rdata`, then goes to DONE.
- DONE: lasts one cycle. `ld_valid`=1 for loads. Always returns to IDLE; no new access is accepted in DONE.
- `stall` = (IDLE & start) | REQ | WAIT. It is combinational, so it rises in the cycle the access is presented.
- Byte enables:
  - width 1: `4'b0001 << addr[1:0]`.
  - width 2: `addr[1]` ? `1100` : `0011`.
  - width 4: `1111`.
- Write data: byte replicated ×4, half replicated ×2, word unchanged.
- Load data: select byte `addr[1:0]` or half `addr[1]` from `mem_rdata`. Sign-extend when `rsign`=1, else zero-extend.
- `mem_addr` = {latched addr[31:2], 2'b00}.
- Misaligned means a half with `addr[0]`=1, or a word with `addr[1:0]`≠0. Handling is set by the configuration macro.
- `mem_rvalid` and `mem_gnt` are ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `ld_valid`, `misalign` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `rdata` = 0.
- `stall` is 0 after reset unless an access is presented.
- Memory port outputs are registered: `mem_req` rises the cycle after acceptance.
- `mem_rvalid` is at least one cycle after `mem_gnt`.
- Minimum latency, with grant on the first REQ cycle and `rvalid` the next cycle:
  - Load: `stall` high for 3 cycles, `ld_valid` in cycle 3.
  - Store: `stall` high for 2 cycles, DONE in cycle 2.
- Back-to-back accesses have at least one idle cycle between them, because of the DONE cycle.
- Reset mid-access (REQ or WAIT): return to IDLE, `mem_req` low the next cycle, and a late `mem_rvalid` is discarded.

## Configuration
- `DCACHE_MISALIGN_TRAP_EN` defined:
  - A misaligned access in IDLE goes directly to DONE; `misalign`=1 in DONE.
  - No `mem_req` is issued and `ld_valid` stays 0.
  - `stall` is high for 1 cycle only.
- Not defined:
  - `misalign` is tied to 0.
  - Offending low address bits are cleared (half: bit 0; word: bits 1:0) and the access proceeds normally.

## Test plan
- LB at 0x103, `mem_rdata`=0x80FF_0000, `rsign`=1 -> `rdata`=0xFFFF_FF80. LBU (`rsign`=0) -> 0x0000_0080.
- LH at 0x102, `mem_rdata`=0x8001_1234 -> `rdata`=0xFFFF_8001. LHU -> 0x0000_8001.
- SH at 0x102, `wdata`=0x1234_ABCD -> `mem_addr`=0x100, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_we`=1. Stall high for 2 cycles with immediate grant.
- LW at 0x102:
  - With the macro: `misalign` pulse, no `mem_req`, 1 stall cycle.
  - Without the macro: `mem_addr`=0x100, `mem_be`=1111.
- Grant delayed 3 cycles -> `mem_req`, `mem_addr`, `mem_be` held constant and `stall` held. `ld_valid` pulses exactly once, in the cycle after the first `mem_rvalid` (DONE).
- `rst` asserted in WAIT, then `mem_rvalid`=1 -> `mem_req`=0, `ld_valid` stays 0, state IDLE.
